// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receive types and constants
// Contents: FSM state encoding, parity type constants, supported prescale values,
// and a 3-input majority helper used by the bit sampler.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_data_sampling.sv
// uart_rx_data_sampling: 3-sample majority voter around the bit centre
// Ports:
//   clk_i, rst_ni   - oversampling clock, asynchronous active-low reset
//   rx_i            - serial line
//   prescale_i      - clock cycles per bit (latched for the current frame)
//   edge_cnt_i      - position within the current bit
//   sampled_bit_o   - majority of the samples at mid-1, mid, mid+1; valid from mid+2
module uart_rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rx_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt_i,
  output logic                      sampled_bit_o
);
  localparam int PW = PRESCALE_WIDTH;
  logic [PW-1:0] mid;
  logic [1:0] smp_q, smp_d;
  logic bit_q, bit_d;
  always_comb begin
    mid      = prescale_i >> 1;
    smp_d    = smp_q;
    smp_d[0] = (edge_cnt_i == mid - PW'(1)) ? rx_i : smp_q[0];
    smp_d[1] = (edge_cnt_i == mid) ? rx_i : smp_q[1];
    // third sample is taken live and voted in the same cycle
    bit_d    = (edge_cnt_i == mid + PW'(1)) ? maj3(smp_q[0], smp_q[1], rx_i) : bit_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      smp_q <= 2'b11;
      bit_q <= 1'b1;
    end else begin
      smp_q <= smp_d;
      bit_q <= bit_d;
    end
  end
  assign sampled_bit_o = bit_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with optional parity and stop-bit check
// Ports:
//   CLK, RST       - oversampling clock, asynchronous active-low reset
//   RX_IN          - serial line, idle high, already synchronised
//   Prescale       - CLK cycles per bit (8, 16 or 32), latched at frame start
//   parity_enable  - frame carries a parity bit (latched at frame start)
//   parity_type    - 0 even, 1 odd (latched at frame start)
//   P_DATA         - last good byte, held between frames
//   data_valid     - one-cycle pulse with a new good byte
//   parity_error   - one-cycle pulse on parity mismatch
//   stop_error     - one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error
);
  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH + 3);
  rx_state_e state_q, state_d;
  logic [PW-1:0] edge_cnt_q, edge_cnt_d, prescale_q, prescale_d, half;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic par_en_q, par_en_d, par_type_q, par_type_d, par_err_q, par_err_d;
  logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic sampled_bit, bit_end;

  uart_rx_data_sampling #(.PRESCALE_WIDTH(PW)) u_sampling (
    .clk_i         (CLK),
    .rst_ni        (RST),
    .rx_i          (RX_IN),
    .prescale_i    (prescale_q),
    .edge_cnt_i    (edge_cnt_q),
    .sampled_bit_o (sampled_bit)
  );

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_err_d  = par_err_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    half       = prescale_q >> 1;
    bit_end    = edge_cnt_q == prescale_q - PW'(1);
    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PW'(1);
      bit_cnt_d  = bit_end ? bit_cnt_q + BW'(1) : bit_cnt_q;
    end
    case (state_q)
      IDLE: if (!RX_IN) begin
        state_d    = START;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        prescale_d = Prescale;
        par_en_d   = parity_enable;
        par_type_d = parity_type;
        par_err_d  = 1'b0;
      end
      START: if (bit_end) state_d = sampled_bit ? IDLE : DATA;
      DATA: if (bit_end) begin
        shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (bit_cnt_q == BW'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        par_err_d = sampled_bit != (^shift_q ^ (par_type_q == PARITY_ODD));
        state_d   = STOP;
      end
      STOP: if (edge_cnt_q == half + PW'(2)) begin
        // leave half a bit early so a back-to-back start edge is not missed
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        se_d       = !sampled_bit;
        pe_d       = par_err_q;
        dv_d       = sampled_bit && !par_err_q;
        p_data_d   = (sampled_bit && !par_err_q) ? shift_q : p_data_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      prescale_q <= PW'(PRESCALE_8);
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_err_q  <= 1'b0;
      shift_q    <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_err_q  <= par_err_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = dv_q;
  assign parity_error = pe_q;
  assign stop_error   = se_q;
endmodule
